// File: rtl/pulse_train_generator.sv
// pulse_train_generator: programmable pulse train (continuous / one-shot / burst).
// Define PULSE_TRAIN_RETRIGGER_EN to let start restart a running train.
module pulse_train_generator #(
  parameter int N = 8,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [N-1:0] ticks,
  input  logic [N-1:0] width,
  input  logic [C-1:0] burst_count,
  output logic         out,
  output logic         busy,
  output logic         period_tick,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [1:0] mode_q;
  logic [N-1:0] ticks_q, width_q, counter;
  logic [C-1:0] burst_q, pcount;
  logic done_q, valid, retrig, load, terminal, clear;
  assign valid = start && !stop && (mode != 2'd3) && (mode != 2'd2 || burst_count != '0);
`ifdef PULSE_TRAIN_RETRIGGER_EN
  assign retrig = (state == RUN) && start && !stop;
`else
  assign retrig = 1'b0;
`endif
  assign load = start && !stop && (state == IDLE || retrig);
  assign terminal = period_tick && (mode_q == 2'd1 || (mode_q == 2'd2 && pcount == burst_q - C'(1)));
  assign clear = load || state_nx == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // an invalid retrigger (zero burst or reserved mode) acts as stop
  always_comb
    state_nx = (state == IDLE) ? (valid ? RUN : IDLE)
             : (stop || (retrig ? !valid : terminal)) ? IDLE : RUN;
  always_comb begin
    busy = state == RUN;
    out = busy && (counter < ((width_q == '0) ? N'(1) : width_q));
    period_tick = busy && ena && counter == ticks_q && !stop;
    done = done_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= '0;
      ticks_q <= '0;
      width_q <= '0;
      burst_q <= '0;
      counter <= '0;
      pcount <= '0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        mode_q <= mode;
        ticks_q <= ticks;
        width_q <= width;
        burst_q <= burst_count;
      end
      counter <= clear ? '0 : (busy && ena) ? ((counter == ticks_q) ? '0 : counter + N'(1)) : counter;
      pcount <= clear ? '0 : (busy && ena && counter == ticks_q) ? pcount + C'(1) : pcount;
      done_q <= (state == IDLE && start && !stop && mode == 2'd2 && burst_count == '0) || (terminal && !retrig);
    end
endmodule
